// File: rtl/sd_spi_init_ctrl.sv
// sd_spi_init_ctrl: SPI-mode SD/MMC card initialiser (SDv2 / SDv1 / MMC) with timeouts and error codes.
// Ports:
//   d_clock    SPI bit clock, all logic on the rising edge
//   reset      asynchronous active-low reset
//   start      begin initialisation (sampled in IDLE only)
//   MISO/MOSI  card data out / card data in (MOSI registered)
//   CS         chip select, active low, registered
//   card_busy  high from accepted start until READY or ERROR
//   card_ready high in READY
//   init_error high in ERROR, error_code gives the cause
//   card_type  0 unknown, 1 MMC, 2 SDv1, 3 SDv2
//   ccs        OCR[30] for SDv2 (block addressing)
module sd_spi_init_ctrl #(
  parameter int INIT_CLOCKS = 80,
  parameter int GAP_CLOCKS = 8,
  parameter int NCR_MAX = 16,
  parameter int RETRY_WIDTH = 16,
  parameter logic [RETRY_WIDTH-1:0] ACMD41_RETRIES = 16'd4000,
  parameter logic [RETRY_WIDTH-1:0] CMD0_RETRIES = 16'd8
) (
  input  logic       d_clock,
  input  logic       reset,
  input  logic       start,
  input  logic       MISO,
  output logic       MOSI,
  output logic       CS,
  output logic       card_busy,
  output logic       card_ready,
  output logic       init_error,
  output logic [2:0] error_code,
  output logic [1:0] card_type,
  output logic       ccs
);
  typedef enum logic [3:0] {IDLE, POWERUP, SEND, WAIT_R, RECV, GAP, DECIDE, READY, ERROR} state_t;
  typedef enum logic [2:0] {C0, C8, C55, C41, C1, C58, C16} cmd_t;
  localparam logic [15:0] INIT_LAST = 16'(INIT_CLOCKS - 1);
  localparam logic [15:0] GAP_LAST = 16'(GAP_CLOCKS - 1);
  localparam logic [15:0] NCR_LAST = 16'(NCR_MAX * 8 - 1);
  state_t state, state_n;
  cmd_t cmd, cmd_n, nxt;
  logic [15:0] cnt, cnt_n;
  logic [47:0] sh, sh_n, fr;
  logic [39:0] resp, resp_n;
  logic [RETRY_WIDTH-1:0] retry, retry_n, retry_inc, cmd0_cnt, cmd0_n, cmd0_inc;
  logic [2:0] pend, pend_n, code_n;
  logic [1:0] type_n;
  logic [7:0] r1;
  logic mosi_n, cs_n, ccs_n, go, long_resp;
  logic unused_resp;
  function automatic logic [47:0] frame_of(cmd_t c, logic hc);
    logic [5:0] idx;
    logic [31:0] arg;
    logic [7:0] crc;
    idx = c == C0 ? 6'd0 : c == C8 ? 6'd8 : c == C55 ? 6'd55 : c == C41 ? 6'd41 :
          c == C1 ? 6'd1 : c == C58 ? 6'd58 : 6'd16;
    arg = c == C8 ? 32'h0000_01AA : c == C16 ? 32'd512 : (c == C41 && hc) ? 32'h4000_0000 : 32'd0;
    crc = c == C0 ? 8'h95 : c == C8 ? 8'h87 : 8'h01;
    return {2'b01, idx, arg, crc};
  endfunction
  assign card_busy = !(state inside {IDLE, READY, ERROR});
  assign card_ready = state == READY;
  assign init_error = state == ERROR;
  // CMD8 and CMD58 return 40-bit R7/R3 with R1 on top; everything else is a bare R1
  assign long_resp = cmd == C8 || cmd == C58;
  assign r1 = long_resp ? resp[39:32] : resp[7:0];
  assign retry_inc = retry + RETRY_WIDTH'(1);
  assign cmd0_inc = cmd0_cnt + RETRY_WIDTH'(1);
  // OCR/R7 bits outside the echo pattern and CCS carry no meaning here
  assign unused_resp = ^{resp[31], resp[29:12]};
  always_comb begin
    state_n = state;
    cmd_n = cmd;
    nxt = cmd;
    go = 1'b0;
    cnt_n = cnt + 16'd1;
    sh_n = sh;
    resp_n = resp;
    retry_n = retry;
    cmd0_n = cmd0_cnt;
    pend_n = pend;
    mosi_n = 1'b1;
    cs_n = 1'b1;
    code_n = error_code;
    type_n = card_type;
    ccs_n = ccs;
    case (state)
      IDLE: begin
        cnt_n = '0;
        state_n = start ? POWERUP : IDLE;
      end
      POWERUP: if (cnt == INIT_LAST) begin
        go = 1'b1;
        nxt = C0;
      end
      SEND: begin
        cs_n = 1'b0;
        mosi_n = sh[47];
        sh_n = {sh[46:0], 1'b1};
        if (cnt == 16'd47) begin
          state_n = WAIT_R;
          cnt_n = '0;
          mosi_n = 1'b1;
        end
      end
      WAIT_R: begin
        cs_n = 1'b0;
        if (!MISO) begin
          state_n = RECV;
          cnt_n = '0;
          resp_n = '0;
        end else if (cnt == NCR_LAST) begin
          state_n = GAP;
          cnt_n = '0;
          pend_n = 3'd4;
        end
      end
      RECV: begin
        cs_n = 1'b0;
        resp_n = {resp[38:0], MISO};
        if (cnt == (long_resp ? 16'd38 : 16'd6)) begin
          state_n = GAP;
          cnt_n = '0;
        end
      end
      GAP: if (cnt == GAP_LAST) state_n = DECIDE;
      DECIDE: begin
        if (pend != 3'd0) begin
          state_n = ERROR;
          code_n = pend;
        end else case (cmd)
          C0: begin
            cmd0_n = cmd0_inc;
            if (r1 == 8'h01) begin
              go = 1'b1;
              nxt = C8;
            end else if (cmd0_inc == CMD0_RETRIES) begin
              state_n = ERROR;
              code_n = 3'd1;
            end else begin
              go = 1'b1;
              nxt = C0;
            end
          end
          C8: begin
            if (r1[2]) begin
              go = 1'b1;
              nxt = C55;
              type_n = 2'd2;
            end else if (r1 == 8'h01 && resp[11:0] == 12'h1AA) begin
              go = 1'b1;
              nxt = C55;
              type_n = 2'd3;
            end else begin
              state_n = ERROR;
              code_n = 3'd2;
            end
          end
          C55: begin
            go = 1'b1;
            // an SDv1-path card rejecting CMD55 is an MMC card
            if (card_type == 2'd2 && r1[2]) begin
              nxt = C1;
              type_n = 2'd1;
              retry_n = '0;
            end else nxt = C41;
          end
          C41, C1: begin
            retry_n = retry_inc;
            if (r1 == 8'h00) begin
              go = 1'b1;
              nxt = card_type == 2'd3 ? C58 : C16;
            end else if (retry_inc == ACMD41_RETRIES) begin
              state_n = ERROR;
              code_n = 3'd3;
            end else begin
              go = 1'b1;
              nxt = cmd == C41 ? C55 : C1;
            end
          end
          default: begin
            if (r1 == 8'h00) begin
              state_n = READY;
              ccs_n = cmd == C58 ? resp[30] : 1'b0;
            end else begin
              state_n = ERROR;
              code_n = 3'd5;
            end
          end
        endcase
      end
      default: ;
    endcase
    fr = frame_of(nxt, card_type == 2'd3);
    if (go) begin
      state_n = SEND;
      cmd_n = nxt;
      cnt_n = '0;
      cs_n = 1'b0;
      mosi_n = fr[47];
      sh_n = {fr[46:0], 1'b1};
    end
  end
  always_ff @(posedge d_clock or negedge reset)
    if (!reset) begin
      state <= IDLE;
      cmd <= C0;
      cnt <= '0;
      sh <= '0;
      resp <= '0;
      retry <= '0;
      cmd0_cnt <= '0;
      pend <= '0;
      MOSI <= 1'b1;
      CS <= 1'b1;
      error_code <= '0;
      card_type <= '0;
      ccs <= 1'b0;
    end else begin
      state <= state_n;
      cmd <= cmd_n;
      cnt <= cnt_n;
      sh <= sh_n;
      resp <= resp_n;
      retry <= retry_n;
      cmd0_cnt <= cmd0_n;
      pend <= pend_n;
      MOSI <= mosi_n;
      CS <= cs_n;
      error_code <= code_n;
      card_type <= type_n;
      ccs <= ccs_n;
    end
endmodule

// File: doc/sd_spi_init_ctrl.md
Name: sd_spi_init_ctrl

Overview:
- Parametrised SPI-mode SD/MMC card initialiser, successor to the fixed-sequence initialiser.
- Drives a real CS between commands and bounds response and retry timeouts.
- Branches on card generation (SDv2 / SDv1 / MMC), reports card type and CCS (block addressing), and flags errors with a code.
- Sits between the top-level start logic and the SD block reader; the reader waits on card_ready.

Parameters:
INIT_CLOCKS, 80, dummy clocks with CS high and MOSI high after start (must be >= 74)
GAP_CLOCKS, 8, clocks with CS high and MOSI high between commands
NCR_MAX, 16, maximum bytes of 0xFF tolerated before a response start bit
RETRY_WIDTH, 16, width of the retry counter
ACMD41_RETRIES, 16'd4000, maximum ACMD41/CMD1 attempts
CMD0_RETRIES, 16'd8, maximum CMD0 attempts

Ports:
d_clock  input  1  SPI bit clock; drives SCLK externally; all logic on rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  level/pulse; sampled in IDLE only
MISO  input  1  card data out, sampled on rising d_clock
MOSI  output  1  card data in, registered
CS  output  1  chip select, active low, registered
card_busy  output  1  high from start accepted until READY or ERROR
card_ready  output  1  high in READY
init_error  output  1  high in ERROR
error_code  output  3  0 none, 1 CMD0 fail, 2 CMD8 voltage/echo mismatch, 3 init retry exhausted, 4 no response (NCR timeout), 5 CMD16/CMD58 R1 error
card_type  output  2  0 unknown, 1 MMC, 2 SDv1, 3 SDv2
ccs  output  1  OCR[30] for SDv2; 0 otherwise

Behaviour:
- Reset (reset=0, asynchronous): state IDLE. CS=1, MOSI=1, card_busy=0, card_ready=0, init_error=0, error_code=0, card_type=0, ccs=0, all counters 0.
- Frame: 48 bits, MSB first: {01, idx[5:0], arg[31:0], crc7, 1}.
- CRC bytes: CMD0 0x95; CMD8 0x87; all other commands 0x01.
- States:
  - IDLE: wait for start.
  - POWERUP: CS=1, MOSI=1 for INIT_CLOCKS cycles.
  - SEND: CS=0; one bit per cycle, 48 cycles; MOSI=1 after the last bit.
  - WAIT_R: MOSI=1. A 0 sampled on MISO is response bit 7; go to RECV. No start bit within NCR_MAX*8 cycles: ERROR code 4.
  - RECV: shift 7 more bits for R1. For R7/R3 (CMD8, CMD58), shift 39 more bits into a 40-bit register.
  - GAP: CS=1, MOSI=1 for GAP_CLOCKS cycles.
  - DECIDE: one cycle, selects the next command.
  - READY and ERROR are sticky; leaving them requires reset.
- Sequence:
  - CMD0 arg 0: R1==0x01 goes to CMD8. Any other R1 retries CMD0; the CMD0_RETRIES-th failure gives ERROR 1.
  - CMD8 arg 0x000001AA:
    - R1 bit2 (illegal) set: SDv1 path.
    - R1==0x01 and echo[11:0]==0x1AA: SDv2 path.
    - Otherwise: ERROR 2.
  - SD loop: CMD55 arg 0, then ACMD41 (CMD41) with arg 0x40000000 for SDv2, 0 for SDv1.
    - ACMD41 R1==0x00: done.
    - R1==0x01: retry CMD55.
    - CMD55 R1 bit2 on the SDv1 path: switch to the MMC loop; the retry counter is cleared.
  - MMC loop: CMD1 arg 0 until R1==0x00.
  - Retry counter increments once per ACMD41/CMD1 attempt. Reaching ACMD41_RETRIES without success gives ERROR 3.
  - After init:
    - SDv2: CMD58. R1 must be 0x00, else ERROR 5. ccs = OCR bit30.
    - SDv1/MMC: CMD16 arg 512. R1 must be 0x00, else ERROR 5.
  - Then READY.
- card_type is set at the branch decision: 3 after a good CMD8, 2 on illegal CMD8, overwritten to 1 on the MMC switch. It is held in ERROR and READY.
- start during a non-IDLE state is ignored.
- Every error exit passes through one GAP before entering ERROR, so CS=1 in ERROR.
- Reset mid-frame returns to IDLE immediately: CS=1, MOSI=1 on the reset assertion, with no partial-frame completion.

Test Plan:
- SDv2 card model (CMD0->0x01, CMD8->0x01+0x000001AA, ACMD41 0x01 three times then 0x00, CMD58 OCR 0xC0FF8000) -> card_ready=1, card_type=3, ccs=1, error_code=0. Exactly 80 CS-high clocks precede the first SEND. CMD0 frame is 0x400000000095.
- SDv1 model (CMD8->0x05, ACMD41 succeeds) -> CMD16 frame 0x500000020001 sent; card_type=2, ccs=0, card_ready=1.
- MMC model (CMD8->0x05, CMD55->0x05, CMD1 0x01 then 0x00) -> card_type=1, card_ready=1. No ACMD41 sent after the CMD55 failure.
- MISO stuck high -> after CMD0 plus NCR_MAX*8 cycles plus GAP: init_error=1, error_code=4, CS=1.
- CMD8 echo 0x000001A5 -> ERROR code 2. ACMD41 always 0x01 with ACMD41_RETRIES=5 -> exactly 5 ACMD41 frames, then ERROR code 3.
- reset=0 asserted mid-SEND of CMD8 -> CS=1, MOSI=1, all outputs at reset values within the same cycle. Re-asserting start restarts POWERUP.
